// File: rtl/vga_controller_if.sv
// VGA controller bus: renderer colour inputs, scan position and DAC/sync outputs.
// The master modport belongs to the controller, the slave modport to the renderer/DAC side.
interface vga_controller_if;
  logic [7:0] R_in;
  logic [7:0] G_in;
  logic [7:0] B_in;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic       VGA_CLK;
  logic       frame_start;

  modport master (
    input  R_in, G_in, B_in,
    output h_counter, v_counter, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
    output VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start
  );

  modport slave (
    output R_in, G_in, B_in,
    input  h_counter, v_counter, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
    input  VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start
  );
endinterface

// File: rtl/vga_controller.sv
// VGA timing generator and registered pixel output stage.
// A divide-by-two toggle produces the pixel enable; all scan counters and output
// registers advance only on pixel-enable cycles, giving one pixel of output latency.
// Optional macro VGA_BORDER_EN: forces a white one-pixel frame around the visible area.
module vga_controller #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input logic              clk,
  input logic              reset_n,
  vga_controller_if.master bus
);

  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HLast      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] VLast      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       r_pix_en;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic [7:0] r_red;
  logic [7:0] r_grn;
  logic [7:0] r_blu;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;
  logic       r_frame_start;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_visible;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic [7:0] w_red;
  logic [7:0] w_grn;
  logic [7:0] w_blu;

  assign w_h_last  = (r_h == HLast);
  assign w_v_last  = (r_v == VLast);
  assign w_visible = (r_h < HVis) && (r_v < VVis);
  assign w_hs_raw  = !((r_h >= HSyncStart) && (r_h < HSyncEnd));
  assign w_vs_raw  = !((r_v >= VSyncStart) && (r_v < VSyncEnd));

`ifdef VGA_BORDER_EN
  logic w_border;
  assign w_border = (r_h == 10'd0) || (r_h == HVis - 10'd1) ||
                    (r_v == 10'd0) || (r_v == VVis - 10'd1);
`endif

  // Pixel colour selection: renderer colour in the visible area, black in blanking.
  always_comb begin
    w_red = 8'h00;
    w_grn = 8'h00;
    w_blu = 8'h00;
    if (w_visible) begin
      w_red = bus.R_in;
      w_grn = bus.G_in;
      w_blu = bus.B_in;
`ifdef VGA_BORDER_EN
      if (w_border) begin
        w_red = 8'hFF;
        w_grn = 8'hFF;
        w_blu = 8'hFF;
      end
`endif
    end
  end

  // Pixel-enable toggle: high on every second clk, doubles as the pixel clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_en <= 1'b0;
    end else begin
      r_pix_en <= ~r_pix_en;
    end
  end

  // Horizontal and vertical scan counters, wrapping at the line and frame totals.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h <= 10'd0;
      r_v <= 10'd0;
    end else if (r_pix_en) begin
      if (w_h_last) begin
        r_h <= 10'd0;
        r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // Output stage: colour, sync and blank registered together so they stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_red     <= 8'h00;
      r_grn     <= 8'h00;
      r_blu     <= 8'h00;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else if (r_pix_en) begin
      r_red     <= w_red;
      r_grn     <= w_grn;
      r_blu     <= w_blu;
      r_hs      <= w_hs_raw;
      r_vs      <= w_vs_raw;
      r_blank_n <= w_visible;
    end
  end

  // Frame start: single-clk pulse when both counters wrap back to the origin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= r_pix_en && w_h_last && w_v_last;
    end
  end

  assign bus.h_counter   = r_h;
  assign bus.v_counter   = r_v;
  assign bus.VGA_R       = r_red;
  assign bus.VGA_G       = r_grn;
  assign bus.VGA_B       = r_blu;
  assign bus.VGA_HS      = r_hs;
  assign bus.VGA_VS      = r_vs;
  assign bus.VGA_BLANK_N = r_blank_n;
  assign bus.VGA_SYNC_N  = 1'b0;
  assign bus.VGA_CLK     = r_pix_en;
  assign bus.frame_start = r_frame_start;

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48; horizontal porch and sync widths in pixels (line total 800).
REQ-003 Parameter V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33; vertical widths in lines (frame total 525).
REQ-004 clk  input  1  50 MHz system clock; the block uses a single clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 R_in, G_in, B_in  input  8 each  pixel colour from the combinational renderers, valid for the current h_counter/v_counter.
REQ-007 h_counter  output  10  current horizontal pixel position, 0..799.
REQ-008 v_counter  output  10  current line position, 0..524.
REQ-009 VGA_R, VGA_G, VGA_B  output  8 each  registered pixel colour to the DAC.
REQ-010 VGA_HS, VGA_VS  output  1  sync pulses, active low.
REQ-011 VGA_BLANK_N  output  1  high during the visible area.
REQ-012 VGA_SYNC_N  output  1  held at constant 0.
REQ-013 VGA_CLK  output  1  25 MHz pixel clock, equal to the pixel-enable toggle.
REQ-014 frame_start  output  1  one-clk pulse at the start of each frame.

Function
REQ-015 A toggle flop SHALL generate pix_en, high on every second clk; all counters advance only when pix_en=1.
REQ-016 h_counter SHALL increment when pix_en=1 and wrap from 799 to 0.
REQ-017 v_counter SHALL increment when h_counter wraps, and SHALL wrap from 524 to 0 when h_counter and v_counter wrap together.
REQ-018 visible SHALL be high when h_counter<640 and v_counter<480.
REQ-019 hs_raw SHALL be low for h_counter in 656..751.
REQ-020 vs_raw SHALL be low for v_counter in 490..491.
REQ-021 On a pix_en cycle, VGA_R/G/B SHALL register R_in/G_in/B_in when visible=1, and 0 otherwise.
REQ-022 VGA_HS, VGA_VS and VGA_BLANK_N SHALL register hs_raw, vs_raw and visible on the same pix_en edge, so colour and sync align with a fixed latency of one pixel.
REQ-023 frame_start SHALL pulse for one clk on the pix_en cycle where h_counter and v_counter both wrap to 0.
REQ-024 Outputs SHALL hold their values on non-pix_en cycles.
REQ-025 Input colour SHALL never reach the outputs during blanking, even when a renderer drives non-zero there.

Reset
REQ-026 While reset_n=0, the following SHALL be forced asynchronously:
- h_counter=0, v_counter=0, pix_en toggle=0;
- VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_start=0.
REQ-027 Reset asserted mid-line SHALL abort the line immediately.
REQ-028 After reset_n rises, counting SHALL restart at (0,0) on the second clk edge, and the first frame_start SHALL occur only after a full frame.
REQ-029 reset_n SHALL be used directly; deassertion synchronisation is external.

Configuration
REQ-030 With macro VGA_BORDER_EN defined, visible pixels where h_counter is 0 or 639, or v_counter is 0 or 479, SHALL output 0xFF on all three channels, overriding R_in/G_in/B_in.
REQ-031 With VGA_BORDER_EN undefined, no border logic SHALL exist and behaviour SHALL be exactly REQ-021.

Verification
REQ-032 Release reset, count clk edges -> h_counter reaches 1 after 2 clks, and one line is 1600 clks.
REQ-033 Run 1 frame -> VGA_HS low for exactly 96 pixels per line, VGA_VS low for exactly 2 lines, and frame_start pulses once every 840000 clks.
REQ-034 Drive R_in=0xAA, G_in=0x55, B_in=0x0F constantly -> outputs carry those values only while VGA_BLANK_N=1, and are 0 in blanking.
REQ-035 Drive R_in=h_counter[7:0] -> VGA_R equals the previous pixel's h_counter (1-pixel latency).
REQ-036 Assert reset_n=0 at h_counter=300, v_counter=200 -> all outputs reach reset values immediately, and counting resumes from 0,0 after release.
REQ-037 With VGA_BORDER_EN defined and inputs 0 -> pixels (0,y), (639,y), (x,0) and (x,479) are 0xFFFFFF, and all interior pixels are 0.
